// File: rtl/ex_div_ctrl.sv
// ex_div_ctrl: radix-2 restoring DIV/DIVU/REM/REMU sequencer for the EX stage.
// Define DIV_EARLY_OUT_EN to skip CALC for divide-by-zero and signed overflow.
module ex_div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             flush_i,
    input  logic             fc_stall_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             stall_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONES = '1;
    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             remop_q, remop_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic             sgn;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             is_zero;
    logic             is_ovf;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [WIDTH-1:0] fix_val;

    assign accept  = start_i & ~flush_i;
    assign sgn     = ~op_i[0];
    assign a_neg   = sgn & dividend_i[WIDTH-1];
    assign b_neg   = sgn & divisor_i[WIDTH-1];
    assign a_mag   = a_neg ? -dividend_i : dividend_i;
    assign b_mag   = b_neg ? -divisor_i : divisor_i;
    assign is_zero = (divisor_i == '0);
    assign is_ovf  = sgn & (dividend_i == MINV) & (divisor_i == ONES);

    // 33-bit trial keeps the borrow even when |divisor| has its top bit set
    assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};

    assign q_fix = qneg_q ? -quo_q : quo_q;
    assign r_fix = rneg_q ? -rem_q : rem_q;

    always_comb begin
        fix_val = q_fix;
        if (zero_q) begin
            fix_val = remop_q ? dvd_q : ONES;
        end else if (ovf_q) begin
            fix_val = remop_q ? '0 : MINV;
        end else if (remop_q) begin
            fix_val = r_fix;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        dvd_d   = dvd_q;
        res_d   = res_q;
        remop_d = remop_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = a_mag;
                    dvs_d   = b_mag;
                    dvd_d   = dividend_i;
                    remop_d = op_i[1];
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    zero_d  = is_zero;
                    ovf_d   = is_ovf;
`ifdef DIV_EARLY_OUT_EN
                    state_d = (is_zero | is_ovf) ? S_FIX : S_CALC;
`else
                    state_d = S_CALC;
`endif
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + CW'(1);
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                res_d   = fix_val;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (!fc_stall_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // a killed operation must leave the last good result visible
        if (flush_i) begin
            state_d = S_IDLE;
            res_d   = res_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            dvd_q   <= '0;
            res_q   <= '0;
            remop_q <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            dvd_q   <= dvd_d;
            res_q   <= res_d;
            remop_q <= remop_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy_o   = (state_q == S_CALC) | (state_q == S_FIX);
    assign done_o   = (state_q == S_DONE);
    assign result_o = res_q;
    assign stall_o  = ((state_q == S_IDLE) & accept) | busy_o;

endmodule

// File: tb/tb_ex_div_ctrl.sv
// tb_ex_div_ctrl: directed vectors for ex_div_ctrl against a latency/arithmetic
// reference model, plus literal expectations for results and timing.
module tb_ex_div_ctrl;

    localparam logic [1:0] DIV  = 2'd0;
    localparam logic [1:0] DIVU = 2'd1;
    localparam logic [1:0] REM  = 2'd2;
    localparam logic [1:0] REMU = 2'd3;

`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    localparam int SPL = EARLY ? 2 : 34;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        flush_i;
    logic        fc_stall_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;
    logic        stall_o;

    ex_div_ctrl #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .op_i       (op_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .flush_i    (flush_i),
        .fc_stall_i (fc_stall_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .stall_o    (stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            if (errs <= 40)
                $display("FAIL %s at cycle %0d: got %h, want %h",
                         nm, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'd0 : 32'h8000_0000;
        case (op)
            DIV:     return $signed(a) / $signed(b);
            DIVU:    return a / b;
            REM:     return $signed(a) % $signed(b);
            default: return a % b;
        endcase
    endfunction

    function automatic bit special(input logic [1:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        return (b == 32'd0) ||
               (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Model: an accepted op is in flight for lat-1 cycles, then DONE holds
    // the result until fc releases it; flush drops everything.
    typedef enum int {M_IDLE, M_RUN, M_DONE} mode_e;
    mode_e       m_mode;
    int          m_t0;
    int          m_lat;
    logic [31:0] m_exp;
    logic [31:0] m_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = M_IDLE;
            m_res  = 32'd0;
        end else begin
            if (flush_i) begin
                m_mode = M_IDLE;
            end else begin
                case (m_mode)
                    M_IDLE: if (start_i) begin
                        m_mode = M_RUN;
                        m_t0   = cyc;
                        m_exp  = ref_res(op_i, dividend_i, divisor_i);
                        m_lat  = (EARLY && special(op_i, dividend_i, divisor_i))
                                 ? 2 : 34;
                    end
                    M_RUN: if (cyc + 1 == m_t0 + m_lat) begin
                        m_mode = M_DONE;
                        m_res  = m_exp;
                    end
                    default: if (!fc_stall_i) m_mode = M_IDLE;
                endcase
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        chk("busy", {31'd0, busy_o}, {31'd0, m_mode == M_RUN});
        chk("done", {31'd0, done_o}, {31'd0, m_mode == M_DONE});
        chk("stall", {31'd0, stall_o},
            {31'd0, (m_mode == M_RUN) ||
                    (m_mode == M_IDLE && start_i && !flush_i)});
        chk("result", result_o, m_res);
    end

    task automatic run_op(input string nm, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat,
                          input int nstall);
        int t0;
        int dcount;
        bit seen;
        @(posedge clk);
        #1;
        op_i       = op;
        dividend_i = a;
        divisor_i  = b;
        start_i    = 1'b1;
        fc_stall_i = (nstall > 0);
        t0         = cyc;
        seen       = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done_o) begin
                seen = 1'b1;
                break;
            end
        end
        chk({nm, " done seen"}, {31'd0, seen}, 32'd1);
        chk({nm, " latency"}, cyc - t0, exp_lat);
        chk({nm, " value"}, result_o, exp);
        dcount = seen ? 1 : 0;
        for (int k = 1; k <= nstall; k++) begin
            @(posedge clk);
            #1;
            if (k == nstall) fc_stall_i = 1'b0;
            @(negedge clk);
            if (done_o) dcount++;
        end
        if (nstall > 0)
            chk({nm, " done length"}, dcount, nstall + 1);
    endtask

    task automatic go_idle();
        @(posedge clk);
        #1;
        start_i    = 1'b0;
        fc_stall_i = 1'b0;
        flush_i    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        rst_n      = 1'b0;
        start_i    = 1'b0;
        op_i       = DIV;
        dividend_i = 32'd0;
        divisor_i  = 32'd0;
        flush_i    = 1'b0;
        fc_stall_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy", {31'd0, busy_o}, 32'd0);
        chk("reset done", {31'd0, done_o}, 32'd0);
        chk("reset stall", {31'd0, stall_o}, 32'd0);
        chk("reset result", result_o, 32'd0);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_op("divu 100/7", DIVU, 32'd100, 32'd7, 32'd14, 34, 0);
        go_idle();
        @(negedge clk);
        chk("idle after done", {31'd0, busy_o | done_o}, 32'd0);

        // flush at T+10 kills the op without touching result_o
        @(posedge clk);
        #1;
        op_i       = DIVU;
        dividend_i = 32'h1234_5678;
        divisor_i  = 32'd17;
        start_i    = 1'b1;
        repeat (10) @(posedge clk);
        #1 flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        chk("flush idle", {31'd0, busy_o}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done_o) seen = 1'b1;
        end
        chk("flush no done", {31'd0, seen}, 32'd0);
        chk("flush keeps result", result_o, 32'd14);

        run_op("divu 9/3", DIVU, 32'd9, 32'd3, 32'd3, 34, 0);
        go_idle();

        // flush together with start in IDLE: nothing is accepted
        @(posedge clk);
        #1;
        op_i       = DIVU;
        dividend_i = 32'd50;
        divisor_i  = 32'd5;
        start_i    = 1'b1;
        flush_i    = 1'b1;
        @(negedge clk);
        chk("flush+start stall", {31'd0, stall_o}, 32'd0);
        go_idle();
        @(negedge clk);
        chk("flush+start busy", {31'd0, busy_o}, 32'd0);
        chk("flush+start result", result_o, 32'd3);

        run_op("rem -7%2", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0);
        run_op("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0);
        run_op("div 7/-2", DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 0);
        run_op("rem 7%-2", REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 34, 0);
        run_op("div ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h8000_0000, SPL, 0);
        run_op("rem ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SPL, 0);
        run_op("div 5/0", DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, SPL, 0);
        run_op("remu 5/0", REMU, 32'd5, 32'd0, 32'd5, SPL, 0);
        run_op("divu big", DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 34, 0);
        run_op("remu big", REMU, 32'hFFFF_FFFF, 32'h8000_0001,
               32'h7FFF_FFFE, 34, 0);
        go_idle();

        // fc holds the result for 3 cycles; start stays high through DONE
        run_op("divu fc hold", DIVU, 32'd100, 32'd7, 32'd14, 34, 3);
        go_idle();
        @(negedge clk);
        chk("no restart after done", {31'd0, busy_o}, 32'd0);

        // reset in the middle of CALC
        @(posedge clk);
        #1;
        op_i       = DIV;
        dividend_i = 32'd1000;
        divisor_i  = 32'd10;
        start_i    = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst_n   = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        chk("midreset busy", {31'd0, busy_o}, 32'd0);
        chk("midreset result", result_o, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_op("div after reset", DIV, 32'd1000, 32'hFFFF_FFF6,
               32'hFFFF_FF9C, 34, 0);
        go_idle();
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/ex_div_ctrl.md
# ex_div_ctrl

Multi-cycle sequencer for the RV32M divide/remainder datapath of the EX stage. It replaces the single-cycle `/` and `%` path with a radix-2 restoring iteration of one quotient bit per cycle. While an operation is in flight it holds the pipeline through the flow controller (fc), and it presents a RISC-V-compliant result when the operation completes. It sits beside the EX ALU, takes operands from id_ex_reg, and sends its stall request to fc.

## Interface
- `WIDTH`, default 32: operand/result width. Only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  EX holds a DIV/DIVU/REM/REMU instruction; level, held for as long as the instruction stays in EX.
- `op_i`  in  2  operation code: 00 DIV, 01 DIVU, 10 REM, 11 REMU. Sampled on accept.
- `dividend_i`  in  WIDTH  rs1 value. Sampled on accept.
- `divisor_i`  in  WIDTH  rs2 value. Sampled on accept.
- `flush_i`  in  1  fc kills the EX instruction.
- `fc_stall_i`  in  1  fc is stalling EX for another reason, so the result cannot be consumed yet.
- `busy_o`  out  1  high in CALC and FIX.
- `done_o`  out  1  high in DONE; `result_o` is valid.
- `result_o`  out  WIDTH  quotient or remainder.
- `stall_o`  out  1  request to fc to hold IF..EX.

## Operation
States and transitions:
- IDLE
  - `start_i & ~flush_i` → accept: latch `op_i` and the operand magnitudes, record the sign flags, clear the counter, go to CALC.
- CALC
  - Each cycle: shift `{rem,quo}` left by 1 and form trial = rem − |divisor|.
  - If trial ≥ 0, rem = trial and the new quotient bit is 1; otherwise rem is unchanged and the bit is 0.
  - Counter increments; after WIDTH iterations go to FIX.
- FIX
  - Apply sign correction and the special cases, register `result_o`, go to DONE.
- DONE
  - Stay while `fc_stall_i` = 1.
  - Go to IDLE when `fc_stall_i` = 0.
  - `start_i` is ignored in DONE, because the same instruction is still present.

Arithmetic:
- Signed ops (DIV, REM) use two's-complement magnitudes. |−2^31| = 0x8000_0000, held as an unsigned value.
- DIV: the quotient is negated when the operand signs differ.
- REM: the remainder takes the sign of the dividend.
- Divisor = 0: DIV/DIVU return 0xFFFF_FFFF; REM/REMU return the dividend unchanged.
- Signed overflow (0x8000_0000 / 0xFFFF_FFFF): DIV returns 0x8000_0000; REM returns 0.

`stall_o` = (IDLE & `start_i` & ~`flush_i`) | CALC | FIX. It is combinational from `start_i` in IDLE and 0 in DONE, so EX advances and captures `result_o`.

Boundary conditions:
- `flush_i` in any state: next state is IDLE, `done_o` is never raised for the killed operation, and `result_o` keeps its old value.
- `flush_i` and `start_i` together in IDLE: flush wins and nothing is accepted.
- Reset mid-operation: everything returns to reset values immediately.
- A new start is possible in the IDLE cycle that immediately follows DONE.

## Timing
- Reset values:
  - state IDLE, counter 0;
  - `busy_o` 0, `done_o` 0, `result_o` 0;
  - `stall_o` 0 as long as `start_i` = 0.
- Accept in cycle T:
  - CALC occupies T+1..T+WIDTH;
  - FIX is T+WIDTH+1;
  - `done_o` = 1 from T+WIDTH+2.
- Normal latency is 34 cycles for WIDTH = 32.
- `result_o` is stable from the first DONE cycle until the next FIX or the next early-out completion; it is not cleared by flush.
- `done_o` lasts exactly 1 cycle when `fc_stall_i` = 0 during DONE, and lasts longer for as long as `fc_stall_i` is held high.

## Configuration
- `DIV_EARLY_OUT_EN` defined:
  - Divisor = 0 and signed overflow are detected at accept.
  - The FSM goes IDLE → FIX directly, skipping CALC, so `done_o` rises at T+2.
- `DIV_EARLY_OUT_EN` undefined:
  - Special cases run through all WIDTH CALC cycles.
  - The result is overridden in FIX and is identical in value to the defined case.
  - Latency is always WIDTH+2.

## Test plan
- DIVU 100 / 7, `fc_stall_i` = 0 → `stall_o` high T..T+33; `done_o` = 1 at T+34 only, `result_o` = 14; state returns to IDLE.
- REM −7 (0xFFFF_FFF9) % 2 → `result_o` = 0xFFFF_FFFF. DIV −7 / 2 → `result_o` = 0xFFFF_FFFD.
- DIV 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000; REM on the same operands → 0.
- DIV 5 / 0 → 0xFFFF_FFFF; REMU 5 / 0 → 5.
  - With `DIV_EARLY_OUT_EN`: `done_o` at T+2.
  - Without it: `done_o` at T+34.
- `flush_i` pulsed at T+10 of a DIVU → IDLE at T+11; `done_o` is never raised and `result_o` is unchanged. A new DIVU 9 / 3 then completes with 3.
- `fc_stall_i` = 1 for 3 cycles from the first DONE cycle → `done_o` high for 4 cycles and `stall_o` = 0 throughout. `start_i` held high during DONE does not start a new operation.
